flappy_bird_text_overlay: RTL

- Pixel-pipeline stage directly downstream of the "text_on" PIO register. Consumes its single-bit out_port as text_on.
- Overlays a fixed "GAME OVER" banner (8x8 font, power-of-two scaled) onto the VGA RGB stream.
- Banner shows steadily for HOLD_FRAMES after text_on rises, then blinks.
- Sits between the game renderer's RGB output and the VGA DAC register stage.

---
 rtl/flappy_bird_text_pkg.sv | 40 ++++
 rtl/flappy_bird_text_font_rom.sv | 38 +++
 rtl/flappy_bird_text_overlay.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/flappy_bird_text_pkg.sv
// Shared types and constants for the "GAME OVER" text overlay: banner FSM
// states, glyph codes and the string-to-glyph table.
package flappy_bird_text_pkg;

    typedef enum logic [1:0] {
        ST_OFF,
        ST_SHOW,
        ST_BLINK_ON,
        ST_BLINK_OFF
    } banner_state_t;

    typedef logic [2:0] glyph_t;

    localparam glyph_t GLYPH_SPACE = 3'd0;
    localparam glyph_t GLYPH_G     = 3'd1;
    localparam glyph_t GLYPH_A     = 3'd2;
    localparam glyph_t GLYPH_M     = 3'd3;
    localparam glyph_t GLYPH_E     = 3'd4;
    localparam glyph_t GLYPH_O     = 3'd5;
    localparam glyph_t GLYPH_V     = 3'd6;
    localparam glyph_t GLYPH_R     = 3'd7;

    localparam int unsigned CHAR_W    = 8;
    localparam int unsigned CHAR_H    = 8;
    localparam int unsigned NUM_CHARS = 9;

    localparam glyph_t BANNER_STRING [NUM_CHARS] = '{
        GLYPH_G, GLYPH_A, GLYPH_M, GLYPH_E, GLYPH_SPACE,
        GLYPH_O, GLYPH_V, GLYPH_E, GLYPH_R
    };

    // Character positions past the end of the string render as blanks.
    function automatic glyph_t glyph_at(input logic [3:0] idx);
        if (idx < 4'(NUM_CHARS)) begin
            return BANNER_STRING[idx];
        end
        return GLYPH_SPACE;
    endfunction

endpackage

// File: rtl/flappy_bird_text_font_rom.sv
// 64x8 synchronous glyph ROM: address {glyph_code, row}, one-cycle registered
// read, bit 7 of each row is the leftmost pixel.
module flappy_bird_text_font_rom (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] addr,
    output logic [7:0] data
);

    // One 64-bit word per glyph, row 0 in the most significant byte.
    localparam logic [63:0] FONT [8] = '{
        64'h0000000000000000,   // space
        64'h3C66606E66663E00,   // G
        64'h183C66667E666600,   // A
        64'h63777F6B63636300,   // M
        64'h7E60607C60607E00,   // E
        64'h3C66666666663C00,   // O
        64'h66666666663C1800,   // V
        64'h7C66667C786C6600    // R
    };

    logic [63:0] glyph_bits;
    logic [7:0]  row_bits;

    always_comb begin
        glyph_bits = FONT[addr[5:3]];
        row_bits   = glyph_bits[{~addr[2:0], 3'b000} +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data <= '0;
        end else begin
            data <= row_bits;
        end
    end

endmodule

// File: rtl/flappy_bird_text_overlay.sv
// Three-stage pixel pipeline overlaying a blinking "GAME OVER" banner on the
// VGA RGB stream. Optional darkened backing box: define TEXT_BG_BOX_EN.
module flappy_bird_text_overlay #(
    parameter logic [10:0] TEXT_X       = 11'd232,
    parameter logic [9:0]  TEXT_Y       = 10'd224,
    parameter int unsigned SCALE_LOG2   = 1,
    parameter int unsigned HOLD_FRAMES  = 120,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter logic [23:0] TEXT_RGB     = 24'hFFFFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        text_on,
    input  logic        pixel_valid,
    input  logic [10:0] pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic [23:0] rgb_in,
    output logic [23:0] rgb_out,
    output logic        valid_out,
    output logic        banner_visible
);

    import flappy_bird_text_pkg::*;

    localparam logic [10:0] BOX_W      = 11'((NUM_CHARS * CHAR_W) << SCALE_LOG2);
    localparam logic [9:0]  BOX_H      = 10'(CHAR_H << SCALE_LOG2);
    localparam logic [7:0]  HOLD_LAST  = 8'(HOLD_FRAMES - 1);
    localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

    // ---------------------------------------------------------------- FSM
    banner_state_t state, state_n;
    logic [7:0]    cnt, cnt_n;
    logic          frame_tick;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign frame_tick = pixel_valid && (pixel_x == '0) && (pixel_y == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_OFF;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // text_on=0 is checked before any expiry so dropping the enable wins.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (frame_tick) begin
            if (!text_on) begin
                state_n = ST_OFF;
                cnt_n   = '0;
            end else begin
                unique case (state)
                    ST_OFF: begin
                        state_n = ST_SHOW;
                        cnt_n   = '0;
                    end
                    ST_SHOW: begin
                        if (cnt == HOLD_LAST) begin
                            state_n = ST_BLINK_ON;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = sat_inc(cnt);
                        end
                    end
                    ST_BLINK_ON: begin
                        if (cnt == BLINK_LAST) begin
                            state_n = ST_BLINK_OFF;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = sat_inc(cnt);
                        end
                    end
                    ST_BLINK_OFF: begin
                        if (cnt == BLINK_LAST) begin
                            state_n = ST_BLINK_ON;
                            cnt_n   = '0;
                        end else begin
                            cnt_n = sat_inc(cnt);
                        end
                    end
                    default: begin
                        state_n = ST_OFF;
                        cnt_n   = '0;
                    end
                endcase
            end
        end
    end

    assign banner_visible = (state == ST_SHOW) || (state == ST_BLINK_ON);

    // ---------------------------------------------------------------- S0
    logic [11:0] gx_diff;
    logic [10:0] gy_diff;
    logic        in_box_c;

    always_comb begin
        gx_diff  = {1'b0, pixel_x} - {1'b0, TEXT_X};
        gy_diff  = {1'b0, pixel_y} - {1'b0, TEXT_Y};
        in_box_c = !gx_diff[11] && (gx_diff[10:0] < BOX_W) &&
                   !gy_diff[10] && (gy_diff[9:0] < BOX_H);
    end

    logic        s0_valid;
    logic        s0_in_box;
    logic [3:0]  s0_char;
    logic [2:0]  s0_col;
    logic [2:0]  s0_row;
    logic [23:0] s0_rgb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid  <= 1'b0;
            s0_in_box <= 1'b0;
            s0_char   <= '0;
            s0_col    <= '0;
            s0_row    <= '0;
            s0_rgb    <= '0;
        end else begin
            s0_valid  <= pixel_valid;
            s0_in_box <= in_box_c;
            s0_char   <= 4'(gx_diff[10:0] >> (3 + SCALE_LOG2));
            s0_col    <= 3'(gx_diff[10:0] >> SCALE_LOG2);
            s0_row    <= 3'(gy_diff[9:0] >> SCALE_LOG2);
            s0_rgb    <= rgb_in;
        end
    end

    // ---------------------------------------------------------------- S1
    logic [5:0] rom_addr;
    logic [7:0] rom_data;

    assign rom_addr = {glyph_at(s0_char), s0_row};

    flappy_bird_text_font_rom u_font_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (rom_addr),
        .data    (rom_data)
    );

    logic        s1_valid;
    logic        s1_in_box;
    logic [2:0]  s1_col;
    logic [23:0] s1_rgb;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_in_box <= 1'b0;
            s1_col    <= '0;
            s1_rgb    <= '0;
        end else begin
            s1_valid  <= s0_valid;
            s1_in_box <= s0_in_box;
            s1_col    <= s0_col;
            s1_rgb    <= s0_rgb;
        end
    end

    // ---------------------------------------------------------------- S2
    logic in_banner;
    logic lit;

    // ~col selects bit 7-col, so column 0 reads the leftmost (MSB) pixel.
    always_comb begin
        in_banner = s1_valid && s1_in_box && banner_visible;
        lit       = in_banner && rom_data[~s1_col];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_out   <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= s1_valid;
            if (lit) begin
                rgb_out <= TEXT_RGB;
`ifdef TEXT_BG_BOX_EN
            end else if (in_banner) begin
                rgb_out <= {1'b0, s1_rgb[23:17], 1'b0, s1_rgb[15:9], 1'b0, s1_rgb[7:1]};
`else
`endif
            end else begin
                rgb_out <= s1_rgb;
            end
        end
    end

endmodule
